// File: rtl/subtractor_pkg.sv
// ----------------------------------------------------------------------------
// subtractor_pkg : shared constants and types for the subtractor block
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package subtractor_pkg;

  localparam int unsigned WIDTH_DEFAULT = 1;
  localparam int unsigned WIDTH_MAX     = 64;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } sub_flags_t;

  localparam sub_flags_t FLAGS_RESET = '{cout: 1'b0, ovf: 1'b0, zero: 1'b0};

endpackage : subtractor_pkg

`default_nettype wire

// File: rtl/subtractor_full_sub_cell.sv
// ----------------------------------------------------------------------------
// full_sub_cell : combinational 1-bit full subtractor (a - b - bin)
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_axb;

  assign w_axb = a ^ b;
  assign d     = w_axb ^ bin;
  assign bout  = (~a & b) | (~w_axb & bin);

endmodule : full_sub_cell

`default_nettype wire

// File: rtl/subtractor.sv
// ----------------------------------------------------------------------------
// subtractor : ripple-borrow subtractor with registered difference and flags
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module subtractor
  import subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] m,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             out_valid
);

  logic [WIDTH:0]   w_bw;
  logic [WIDTH-1:0] w_diff;
  sub_flags_t       w_flags;

  logic [WIDTH-1:0] m_d, m_q;
  sub_flags_t       flags_d, flags_q;
  logic             out_valid_d, out_valid_q;

  assign w_bw[0] = cin;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    full_sub_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (w_bw[i]),
      .d    (w_diff[i]),
      .bout (w_bw[i+1])
    );
  end

  // Overflow depends only on sign bits: operands of differing sign whose
  // difference took the sign of the subtrahend.
  always_comb begin
    w_flags.cout = w_bw[WIDTH];
    w_flags.ovf  = (a[WIDTH-1] ^ b[WIDTH-1]) & (w_diff[WIDTH-1] ^ a[WIDTH-1]);
    w_flags.zero = ~|w_diff;
  end

  always_comb begin
    m_d         = m_q;
    flags_d     = flags_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      m_d     = w_diff;
      flags_d = w_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q         <= '0;
      flags_q     <= FLAGS_RESET;
      out_valid_q <= 1'b0;
    end else begin
      m_q         <= m_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign m         = m_q;
  assign cout      = flags_q.cout;
  assign ovf       = flags_q.ovf;
  assign zero      = flags_q.zero;
  assign out_valid = out_valid_q;

endmodule : subtractor

`default_nettype wire

// File: tb/tb_subtractor.sv
// ----------------------------------------------------------------------------
// tb_subtractor : directed and reference-model checks at WIDTH = 1, 8 and 64
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       iv1, ci1, co1, ov1, z1, ovl1;
  logic [0:0] a1, b1, m1;
  logic       iv8, ci8, co8, ov8, z8, ovl8;
  logic [7:0] a8, b8, m8;
  logic        iv64, ci64, co64, ov64, z64, ovl64;
  logic [63:0] a64, b64, m64;

  int checks = 0;
  int errors = 0;

  subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1), .cin(ci1),
    .m(m1), .cout(co1), .ovf(ov1), .zero(z1), .out_valid(ovl1)
  );

  subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8), .cin(ci8),
    .m(m8), .cout(co8), .ovf(ov8), .zero(z8), .out_valid(ovl8)
  );

  subtractor #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv64), .a(a64), .b(b64), .cin(ci64),
    .m(m64), .cout(co64), .ovf(ov64), .zero(z64), .out_valid(ovl64)
  );

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: subtract at 65 bits, borrow is the sign of the wide result.
  function automatic logic [66:0] ref_sub(input int w, input logic [63:0] a,
                                          input logic [63:0] b, input logic cin);
    logic [64:0] d;
    logic [63:0] mask, mm;
    logic        co, ov;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    d    = {1'b0, a & mask} - {1'b0, b & mask} - {64'd0, cin};
    mm   = d[63:0] & mask;
    co   = d[64];
    ov   = (a[w-1] != b[w-1]) && (mm[w-1] != a[w-1]);
    return {(mm == 64'd0), ov, co, mm};
  endfunction

  function automatic logic [71:0] obs8();
    return {4'd0, ovl8, z8, ov8, co8, 56'd0, m8};
  endfunction

  function automatic logic [71:0] obs64();
    return {4'd0, ovl64, z64, ov64, co64, m64};
  endfunction

  logic [3:0]  exp1 [8];
  logic [66:0] r8, r64;

  initial begin
    // entries are {zero, ovf, cout, m} indexed by {a, b, cin}
    exp1 = '{4'b1000, 4'b0011, 4'b0111, 4'b1010, 4'b0001, 4'b1100, 4'b1000, 4'b0011};

    rst_n = 1'b0;
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0; ci1 = 1'b0;
    iv8 = 1'b1; a8 = 8'h33; b8 = 8'h11; ci8 = 1'b0;
    iv64 = 1'b1; a64 = 64'd9; b64 = 64'd2; ci64 = 1'b1;
    #3;
    chk("rst_w1", {67'd0, ovl1, z1, ov1, co1, m1}, 72'd0);
    chk("rst_w8", obs8(), 72'd0);
    chk("rst_w64", obs64(), 72'd0);
    tick();
    chk("rst_ignore_w8", obs8(), 72'd0);
    chk("rst_ignore_w64", obs64(), 72'd0);

    rst_n = 1'b1;
    iv1 = 1'b0; iv8 = 1'b0; iv64 = 1'b0;
    tick();
    chk("idle_after_rst", obs8(), 72'd0);

    // WIDTH=1 exhaustive, back-to-back
    for (int k = 0; k < 8; k++) begin
      logic [2:0] kv;
      kv = k[2:0];
      {a1, b1, ci1} = kv;
      iv1 = 1'b1;
      tick();
      chk($sformatf("w1_abc%0d", k), {67'd0, ovl1, z1, ov1, co1, m1}, {67'd0, 1'b1, exp1[k]});
    end
    iv1 = 1'b0;

    // WIDTH=8 directed, back-to-back
    iv8 = 1'b1; a8 = 8'h05; b8 = 8'h07; ci8 = 1'b0;
    tick();
    chk("w8_05_07", obs8(), {4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 56'd0, 8'hFE});
    a8 = 8'h80; b8 = 8'h01; ci8 = 1'b0;
    tick();
    chk("w8_80_01", obs8(), {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 56'd0, 8'h7F});
    a8 = 8'h00; b8 = 8'hFF; ci8 = 1'b1;
    tick();
    chk("w8_00_FF_c1", obs8(), {4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 56'd0, 8'h00});

    // WIDTH=64 directed
    iv64 = 1'b1; a64 = 64'd0; b64 = 64'd0; ci64 = 1'b1;
    tick();
    chk("w64_0_0_c1", obs64(), {4'd0, 1'b1, 1'b0, 1'b0, 1'b1, {64{1'b1}}});
    a64 = 64'h8000_0000_0000_0000; b64 = 64'd1; ci64 = 1'b0;
    tick();
    chk("w64_min_1", obs64(), {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF});
    iv64 = 1'b0;

    // hold: one accepted op then three idle cycles with toggling operands
    iv8 = 1'b1; a8 = 8'h05; b8 = 8'h07; ci8 = 1'b0;
    tick();
    chk("hold_first", obs8(), {4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 56'd0, 8'hFE});
    iv8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a8 = ~a8; b8 = b8 + 8'h3C; ci8 = ~ci8;
      tick();
      chk($sformatf("hold_idle%0d", k), obs8(), {4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 56'd0, 8'hFE});
    end

    // asynchronous reset between edges while a result is valid
    iv8 = 1'b1; a8 = 8'h10; b8 = 8'h01; ci8 = 1'b0;
    tick();
    chk("pre_async", obs8(), {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 56'd0, 8'h0F});
    iv8 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", obs8(), 72'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_async_idle", obs8(), 72'd0);

    // streaming against the reference model
    iv8 = 1'b1; iv64 = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; ci64 = 1'($urandom);
      if (k % 7 == 0) b64 = a64;
      if (k % 11 == 0) b8 = a8;
      r8  = ref_sub(8, {56'd0, a8}, {56'd0, b8}, ci8);
      r64 = ref_sub(64, a64, b64, ci64);
      tick();
      chk("rnd_w8", obs8(), {4'd0, 1'b1, r8});
      chk("rnd_w64", obs64(), {4'd0, 1'b1, r64});
    end
    iv8 = 1'b0; iv64 = 1'b0;
    tick();
    chk("stream_end_valid", {70'd0, ovl8, ovl64}, 72'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_subtractor

`default_nettype wire

// File: doc/subtractor.md
SUBTRACTOR -- requirements
Module: subtractor

Interface
Parameters:
REQ-001 WIDTH, default 1, operand/difference width in bits; legal range 1..64.
Ports:
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  qualifies a, b and cin in the current cycle.
REQ-005 a  input  WIDTH  minuend, unsigned.
REQ-006 b  input  WIDTH  subtrahend, unsigned.
REQ-007 cin  input  1  borrow-in.
REQ-008 m  output  WIDTH  registered difference.
REQ-009 cout  output  1  registered borrow-out.
REQ-010 ovf  output  1  registered signed (two's-complement) overflow flag.
REQ-011 zero  output  1  registered flag, 1 when m is all zeros.
REQ-012 out_valid  output  1  1 for exactly one cycle per accepted operation.

Function
REQ-013 Arithmetic: m = (a - b - cin) mod 2^WIDTH.
REQ-014 cout = 1 iff a < b + cin, with b + cin evaluated at WIDTH+1 bits.
REQ-015 Per bit i: d_i = a_i ^ b_i ^ bw_i; bw_(i+1) = (~a_i & b_i) | (~(a_i ^ b_i) & bw_i); bw_0 = cin; cout = bw_WIDTH.
REQ-016 WIDTH=1 truth table: m = a^b^cin; cout = (~a&b) | (~(a^b)&cin).
REQ-017 ovf = 1 iff a[MSB] != b[MSB] and m[MSB] != a[MSB]; cin does not change this rule; with WIDTH=1, ovf follows the same rule.
REQ-018 zero = 1 iff every bit of m is 0, including when cout=1 (e.g. a=0, b=all-ones, cin=1 gives m=0).
REQ-019 Latency: when in_valid=1 at rising edge N, m/cout/ovf/zero reflect those operands after edge N, and out_valid=1 during cycle N+1.
REQ-020 When in_valid=0 at an edge, m/cout/ovf/zero hold their previous values and out_valid goes 0.
REQ-021 Back-to-back: in_valid=1 on consecutive edges produces one result per cycle, with no bubbles and no stalls.
REQ-022 No backpressure; a result not consumed is overwritten by the next accepted operation.
REQ-023 Borrow chain and flags are combinational between input sampling and output registers; there is no input register.

Reset
REQ-024 rst_n=0 asynchronously forces m=0, cout=0, ovf=0, zero=0 and out_valid=0, independent of clk.
REQ-025 While rst_n=0, in_valid is ignored; the first operation is accepted at the first rising edge with rst_n=1.
REQ-026 Reset asserted mid-stream discards any pending result; out_valid stays 0 until a new accepted operation.

Structure
REQ-027 Package subtractor_pkg holds the WIDTH default constant (1) and the maximum WIDTH constant (64).
REQ-028 One sub-module, full_sub_cell, is a combinational 1-bit cell (a, b, bin -> d, bout) instantiated WIDTH times in a generate loop.
REQ-029 subtractor holds only the generate chain, flag logic and the output registers.

Verification
REQ-030 WIDTH=1, exhaustive 8 combinations of (a,b,cin) with in_valid=1 -> responses include (0,1,0)->m=1,cout=1; (1,0,1)->m=0,cout=0; (0,0,1)->m=1,cout=1; (1,1,1)->m=1,cout=1; each result appears one cycle later with out_valid=1.
REQ-031 WIDTH=8, a=0x05, b=0x07, cin=0 -> m=0xFE, cout=1, ovf=0, zero=0.
REQ-032 WIDTH=8, a=0x80, b=0x01, cin=0 -> m=0x7F, cout=0, ovf=1; a=0x00, b=0xFF, cin=1 -> m=0x00, cout=1, zero=1.
REQ-033 Apply in_valid=1 then 3 idle cycles with operands toggling -> outputs hold the first result and out_valid is high for exactly one cycle.
REQ-034 Assert rst_n=0 between clock edges while out_valid=1 -> all outputs read 0 immediately, before the next edge.
REQ-035 Random streaming, 10k vectors at WIDTH=8 and WIDTH=64 -> every result matches a reference model (REQ-013..018) with 1-cycle latency.
